hilo_sequencer: RTL and testbench

Multi-cycle sequencer for the Hi/Lo arithmetic resources of the MIPS54 multi-cycle CPU. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time from the main controller and holds the operands stable. It starts the iterative divider, waits for completion under a watchdog, and then issues the Hi/Lo register writes. It sits between the controller, the divider, the combinational multiplier and the Hi/Lo registers.

---
 rtl/hilo_sequencer.sv | 155 +++++++++++++++
 tb/tb_hilo_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_sequencer.sv
// Hi/Lo sequencer: accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO, drives the multiplier/divider, then writes Hi/Lo.
// Optional HILO_DIVZERO_TRAP_EN: a zero divisor skips the divider and reports err=10.
module hilo_sequencer #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done,
  output logic        mult_signed,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI  = 3'd4, OP_MTLO = 3'd5;
  localparam logic [7:0] TO_LAST = 8'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DSTART, S_DWAIT, S_WB} state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_wr_hi, r_wr_lo, r_ready, r_busy, r_done, r_div_start;
  logic [1:0]  r_err;
  logic [7:0]  r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_wr_hi     <= 1'b0;
      r_wr_lo     <= 1'b0;
      r_err       <= 2'b00;
      r_cnt       <= 8'd0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op    <= req_op;
          r_a     <= req_rs;
          r_b     <= req_rt;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          case (req_op)
            OP_MTHI: begin
              r_hi <= req_rs; r_wr_hi <= 1'b1; r_done <= 1'b1; r_state <= S_WB;
            end
            OP_MTLO: begin
              r_lo <= req_rs; r_wr_lo <= 1'b1; r_done <= 1'b1; r_state <= S_WB;
            end
            OP_MULT, OP_MULTU: r_state <= S_MUL;
            OP_DIV, OP_DIVU: begin
`ifdef HILO_DIVZERO_TRAP_EN
              if (req_rt == 32'd0) begin
                r_err <= 2'b10; r_done <= 1'b1; r_state <= S_WB;
              end else begin
                r_div_start <= 1'b1; r_state <= S_DSTART;
              end
`else
              r_div_start <= 1'b1;
              r_state     <= S_DSTART;
`endif
            end
            default: begin
              r_done <= 1'b1; r_state <= S_WB;
            end
          endcase
        end
        S_MUL: begin
          r_hi    <= mult_hi;
          r_lo    <= mult_lo;
          r_wr_hi <= 1'b1;
          r_wr_lo <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_WB;
        end
        S_DSTART: begin
          r_cnt   <= 8'd0;
          r_state <= S_DWAIT;
        end
        S_DWAIT: begin
          // completion beats the watchdog when both land in the same cycle
          if (div_done) begin
            r_hi    <= div_r;
            r_lo    <= div_q;
            r_wr_hi <= 1'b1;
            r_wr_lo <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_WB;
          end else if (r_cnt == TO_LAST) begin
            r_err[0] <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_WB;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WB: begin
          r_wr_hi <= 1'b0;
          r_wr_lo <= 1'b0;
          r_err   <= 2'b00;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // write flags are only ever set on entry to WB, so they double as the enables
  assign req_ready    = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign div_start    = r_div_start;
  assign div_signed   = r_busy & (r_op == OP_DIV);
  assign mult_signed  = r_busy & (r_op == OP_MULT);
  assign div_dividend = r_a;
  assign div_divisor  = r_b;
  assign mult_a       = r_a;
  assign mult_b       = r_b;
  assign hi_we        = r_wr_hi;
  assign lo_we        = r_wr_lo;
  assign hi_wdata     = r_hi;
  assign lo_wdata     = r_lo;
endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: directed table, randomized ops against a rule-level model, reset/long-divide sequences.
module tb_hilo_sequencer;
  localparam int TO = 8;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs = 32'd0, req_rt = 32'd0;
  logic        req_ready, busy, done, div_start, div_signed, mult_signed, hi_we, lo_we, div_done;
  logic [1:0]  err;
  logic [31:0] div_dividend, div_divisor, div_q, div_r, mult_a, mult_b, mult_hi, mult_lo, hi_wdata, lo_wdata;

  logic        b_req_valid = 1'b0, b_div_done = 1'b0;
  logic [2:0]  b_req_op = 3'd0;
  logic [31:0] b_req_rs = 32'd0, b_req_rt = 32'd0, b_div_q = 32'd0, b_div_r = 32'd0;
  logic [31:0] b_mult_hi = 32'd0, b_mult_lo = 32'd0;
  logic        b_req_ready, b_busy, b_done, b_div_start, b_div_signed, b_mult_signed, b_hi_we, b_lo_we;
  logic [1:0]  b_err;
  logic [31:0] b_div_dividend, b_div_divisor, b_mult_a, b_mult_b, b_hi_wdata, b_lo_wdata;

  hilo_sequencer #(.DIV_TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
    .req_ready(req_ready), .busy(busy), .done(done), .err(err), .div_start(div_start),
    .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_q(div_q), .div_r(div_r), .div_done(div_done), .mult_signed(mult_signed),
    .mult_a(mult_a), .mult_b(mult_b), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata));

  hilo_sequencer u_big (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_op(b_req_op), .req_rs(b_req_rs), .req_rt(b_req_rt),
    .req_ready(b_req_ready), .busy(b_busy), .done(b_done), .err(b_err), .div_start(b_div_start),
    .div_signed(b_div_signed), .div_dividend(b_div_dividend), .div_divisor(b_div_divisor),
    .div_q(b_div_q), .div_r(b_div_r), .div_done(b_div_done), .mult_signed(b_mult_signed),
    .mult_a(b_mult_a), .mult_b(b_mult_b), .mult_hi(b_mult_hi), .mult_lo(b_mult_lo),
    .hi_we(b_hi_we), .lo_we(b_lo_we), .hi_wdata(b_hi_wdata), .lo_wdata(b_lo_wdata));

  // environment: divider returns q=all-ones, r=dividend for a zero divisor
  function automatic logic [63:0] divmod(input logic s, input logic [31:0] a, input logic [31:0] b);
    int qi, ri;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      qi = $signed(a) / $signed(b);
      ri = $signed(a) % $signed(b);
      return {32'(ri), 32'(qi)};
    end
    return {a % b, a / b};
  endfunction

  logic [63:0] prod;
  always_comb prod = mult_signed ? {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b}
                                 : {32'd0, mult_a} * {32'd0, mult_b};
  assign {mult_hi, mult_lo} = prod;
  assign {div_r, div_q} = divmod(div_signed, div_dividend, div_divisor);

  int dlat = 0, dcnt = 0;
  always @(posedge clk or posedge reset)
    if (reset) dcnt <= 0;
    else if (div_start) dcnt <= 1;
    else if (dcnt > 0 && dcnt < 1000) dcnt <= dcnt + 1;
  assign div_done = (dlat > 0) && (dcnt == dlat);

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op; logic [31:0] rs, rt; int dl; bit hold;
    logic hwe, lwe; logic [31:0] hi, lo; logic [1:0] err; int lat; int ns;
  } vec_t;

  // reference: outcome straight from the opcode rules and divider latency
  function automatic vec_t model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input int dl, input bit hold);
    vec_t v;
    logic [63:0] p;
    int qi, ri;
    v = '{op, rs, rt, dl, hold, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1, 0};
    case (op)
      3'd4: begin v.hwe = 1; v.hi = rs; end
      3'd5: begin v.lwe = 1; v.lo = rs; end
      3'd0, 3'd1: begin
        if (op == 3'd0) p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        else p = 64'(longint'(rs) * longint'(rt));
        v.hwe = 1; v.lwe = 1; v.hi = p[63:32]; v.lo = p[31:0]; v.lat = 2;
      end
      3'd2, 3'd3: begin
`ifdef HILO_DIVZERO_TRAP_EN
        if (rt == 32'd0) begin v.err = 2'b10; return v; end
`endif
        v.ns = 1;
        if (dl >= 1 && dl <= TO) begin
          v.lat = 2 + dl; v.hwe = 1; v.lwe = 1;
          if (rt == 32'd0) begin v.lo = 32'hFFFFFFFF; v.hi = rs; end
          else if (op == 3'd2) begin
            qi = $signed(rs) / $signed(rt); ri = $signed(rs) % $signed(rt);
            v.lo = 32'(qi); v.hi = 32'(ri);
          end else begin v.lo = rs / rt; v.hi = rs % rt; end
        end else begin
          v.lat = 2 + TO; v.err = 2'b01;
        end
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic run(input vec_t v, input string nm);
    int lat = 0, ns = 0, stray = 0;
    bit acc = 0, got = 0;
    logic hw = 0, lw = 0;
    logic [31:0] hd = 0, ld = 0;
    logic [1:0] e = 0;
    dlat = v.dl;
    req_op = v.op; req_rs = v.rs; req_rt = v.rt; req_valid = 1'b1;
    for (int i = 0; i < 5 && !acc; i++) begin
      if (req_ready) acc = 1; else @(negedge clk);
    end
    chk({nm, "_accept"}, 64'(acc), 64'd1);
    @(posedge clk);
    for (int c = 1; c <= TO + 20 && !got; c++) begin
      @(negedge clk);
      if (v.hold) begin req_op = 3'd4; req_rs = $urandom; end else req_valid = 1'b0;
      if (div_start) ns++;
      if ((hi_we || lo_we) && !done) stray++;
      if (done) begin
        got = 1; lat = c; hw = hi_we; lw = lo_we; hd = hi_wdata; ld = lo_wdata; e = err;
        req_valid = 1'b0;
      end
    end
    chk({nm, "_done"}, 64'(got), 64'd1);
    chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
    chk({nm, "_nstart"}, 64'(ns), 64'(v.ns));
    chk({nm, "_we"}, {62'd0, hw, lw}, {62'd0, v.hwe, v.lwe});
    chk({nm, "_err"}, 64'(e), 64'(v.err));
    chk({nm, "_stray_we"}, 64'(stray), 64'd0);
    if (v.hwe) chk({nm, "_hi"}, 64'(hd), 64'(v.hi));
    if (v.lwe) chk({nm, "_lo"}, 64'(ld), 64'(v.lo));
    @(negedge clk);
    chk({nm, "_idle"}, {62'd0, req_ready, busy}, 64'd2);
  endtask

  vec_t tbl[12];
  vec_t rv;
  int bl;
  bit bgot;

  initial begin
    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 2'b00, 2, 0};
    tbl[1]  = '{3'd1, 32'hFFFFFFFD, 32'd5, 0, 1, 1, 1, 32'h00000004, 32'hFFFFFFF1, 2'b00, 2, 0};
    tbl[2]  = '{3'd3, 32'd17, 32'd5, 5, 1, 1, 1, 32'd2, 32'd3, 2'b00, 7, 1};
    tbl[3]  = '{3'd2, 32'hFFFFFFEF, 32'd5, 3, 0, 1, 1, 32'hFFFFFFFE, 32'hFFFFFFFD, 2'b00, 5, 1};
    tbl[4]  = '{3'd3, 32'd100, 32'd7, 0, 0, 0, 0, 32'd0, 32'd0, 2'b01, 10, 1};
    tbl[5]  = '{3'd2, 32'd100, 32'd7, 8, 0, 1, 1, 32'd2, 32'd14, 2'b00, 10, 1};
    tbl[6]  = '{3'd2, 32'd100, 32'd7, 9, 1, 0, 0, 32'd0, 32'd0, 2'b01, 10, 1};
    tbl[7]  = '{3'd5, 32'h12345678, 32'd0, 0, 1, 0, 1, 32'd0, 32'h12345678, 2'b00, 1, 0};
    tbl[8]  = '{3'd4, 32'h9ABCDEF0, 32'd0, 0, 1, 1, 0, 32'h9ABCDEF0, 32'd0, 2'b00, 1, 0};
    tbl[9]  = '{3'd6, 32'h11111111, 32'd3, 0, 0, 0, 0, 32'd0, 32'd0, 2'b00, 1, 0};
    tbl[10] = '{3'd7, 32'h22222222, 32'd4, 0, 1, 0, 0, 32'd0, 32'd0, 2'b00, 1, 0};
`ifdef HILO_DIVZERO_TRAP_EN
    tbl[11] = '{3'd2, 32'd5, 32'd0, 4, 0, 0, 0, 32'd0, 32'd0, 2'b10, 1, 0};
`else
    tbl[11] = '{3'd2, 32'd5, 32'd0, 4, 0, 1, 1, 32'd5, 32'hFFFFFFFF, 2'b00, 6, 1};
`endif

    #12;
    chk("rst_ready", {62'd0, req_ready, b_req_ready}, 64'd3);
    chk("rst_ctl", {56'd0, busy, done, err, div_start, div_signed, mult_signed, hi_we}, 64'd0);
    chk("rst_data", {lo_we, div_dividend, div_divisor ^ hi_wdata ^ lo_wdata ^ mult_a ^ mult_b}, 65'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      logic [31:0] rs, rt;
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 100)));
      rv = model(3'($urandom_range(0, 7)), rs, rt, $urandom_range(0, TO + 2), bit'($urandom_range(0, 1)));
      run(rv, $sformatf("rnd%0d", i));
    end

    // long divide on the default-timeout instance: done in the 33rd DWAIT cycle
    b_div_q = 32'd3; b_div_r = 32'd2;
    b_req_op = 3'd3; b_req_rs = 32'd17; b_req_rt = 32'd5; b_req_valid = 1'b1;
    @(posedge clk);
    bl = 0; bgot = 0;
    for (int c = 1; c <= 60 && !bgot; c++) begin
      @(negedge clk);
      b_req_valid = 1'b0;
      b_div_done = (c == 34);
      if (b_div_start) bl = bl + 100;
      if (b_done) begin
        bgot = 1; bl = bl + c;
        chk("big_div_data", {b_hi_wdata, b_lo_wdata}, {32'd2, 32'd3});
        chk("big_div_we_err", {60'd0, b_hi_we, b_lo_we, b_err}, 64'hC);
      end
    end
    chk("big_div_lat_start", 64'(bl), 64'd135);
    b_div_done = 1'b0;
    @(negedge clk);

    // reset in the 10th DWAIT cycle aborts with no write and no done
    b_req_op = 3'd3; b_req_rs = 32'd9; b_req_rt = 32'd3; b_req_valid = 1'b1;
    @(posedge clk);
    bgot = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      b_req_valid = 1'b0;
      if (b_done) bgot = 1;
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", {62'd0, b_req_ready, b_busy}, 64'd2);
    chk("rst_mid_ctl", {56'd0, b_done, b_err, b_div_start, b_div_signed, b_mult_signed, b_hi_we, b_lo_we}, 64'd0);
    chk("rst_mid_data", {b_div_dividend, b_div_divisor ^ b_mult_a ^ b_mult_b ^ b_hi_wdata ^ b_lo_wdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b_done || b_hi_we || b_lo_we) bgot = 1;
    end
    chk("rst_mid_nodone", 64'(bgot), 64'd0);

    b_req_op = 3'd4; b_req_rs = 32'hCAFEF00D; b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("post_rst_mthi", {29'd0, b_done, b_hi_we, b_lo_we, b_hi_wdata}, {29'd0, 3'b110, 32'hCAFEF00D});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
